// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - opcode byte values understood by the Processing_Unit
//   - filler characters that are dropped while waiting for an opcode
//   - response status codes and FSM state encoding
//   - small byte classification helpers
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    // Opcode bytes are the ASCII operator characters so a terminal can drive
    // the unit directly: '+', '-', '*', '/', '&', '|'.
    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_DIV = 8'h2F;
    localparam logic [7:0] OP_AND = 8'h26;
    localparam logic [7:0] OP_OR  = 8'h7C;

    // Whitespace / line endings tolerated between commands.
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    // Value returned in place of a quotient when the divisor is zero.
    localparam logic [7:0] DIV0_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_OVF   = 2'b01,
        ST_BADOP = 2'b10,
        ST_DIV0  = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    function automatic logic is_legal_op(input logic [7:0] b);
        return (b == OP_ADD) || (b == OP_SUB) || (b == OP_MUL) ||
               (b == OP_DIV) || (b == OP_AND) || (b == OP_OR);
    endfunction

    function automatic logic is_skip(input logic [7:0] b);
        return (b == CH_SPACE) || (b == CH_LF) || (b == CH_CR);
    endfunction

endpackage : alu_seq_pkg

// File: rtl/alu_command_sequencer.sv
// ---------------------------------------------------------------------------
// alu_command_sequencer
// Byte-stream front end for the Processing_Unit. Collects a three-byte
// command (opcode, operand A, operand B), presents it to the ALU, waits the
// ALU latency, then returns the result byte and a status code through a
// valid/ready response port.
//
// Parameters
//   ALU_LATENCY    : edges from stable operands to valid ALU result (1..15)
//   TIMEOUT_CYCLES : inter-byte timeout, only used with ALU_SEQ_TIMEOUT_EN
//
// Build option
//   ALU_SEQ_TIMEOUT_EN : when defined, a partially received command is
//                        dropped after TIMEOUT_CYCLES idle cycles in
//                        GET_A/GET_B. When undefined, those states wait
//                        indefinitely.
//
// Ports
//   clock, reset       : clock (rising edge), asynchronous active-high reset
//   in_data/in_valid/in_ready      : command byte stream (sink)
//   alu_operation/data_a/data_b    : operands held stable for the ALU
//   alu_result/alu_overflow        : ALU outputs, sampled after the latency
//   out_data/out_status/out_valid/out_ready : response (source)
//   busy               : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_command_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_operation,
    output logic [7:0] alu_data_a,
    output logic [7:0] alu_data_b,
    input  logic [7:0] alu_result,
    input  logic       alu_overflow,
    output logic [7:0] out_data,
    output logic [1:0] out_status,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    // Elaboration-time parameter sanity checks.
    generate
        if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
            $error("alu_command_sequencer: ALU_LATENCY must be 1..15");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
            $error("alu_command_sequencer: TIMEOUT_CYCLES must be 1..65536");
        end
    endgenerate

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

    // -----------------------------------------------------------------------
    // Registers and wires
    // -----------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_alu_operation;
    logic [7:0]  r_alu_data_a;
    logic [7:0]  r_alu_data_b;
    logic [7:0]  r_out_data;
    status_t     r_out_status;
    logic        r_out_valid;
    logic [3:0]  r_wait_cnt;

    logic        w_in_ready;
    logic        w_busy;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_wait_done;
    logic        w_div0;
    logic        w_timeout;

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // The counter holds the number of edges still to go, so the edge that
    // sees 1 is the ALU_LATENCY-th edge after operand B was latched.
    assign w_wait_done = (r_state == WAIT) && (r_wait_cnt == 4'd1);

    // Division by zero is caught on the B byte itself so the ALU result
    // (undefined in that case) is never waited for.
    assign w_div0 = (r_alu_operation == OP_DIV) && (in_data == 8'h00);

    // -----------------------------------------------------------------------
    // Optional inter-byte timeout
    // -----------------------------------------------------------------------
`ifdef ALU_SEQ_TIMEOUT_EN
    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_idle_cnt;
    logic        w_collecting;

    assign w_collecting = (r_state == GET_A) || (r_state == GET_B);

    // Fires on the edge where the idle count would reach TIMEOUT_CYCLES.
    assign w_timeout = w_collecting && !w_in_fire && (r_idle_cnt == IDLE_LIMIT);

    // Held at zero outside GET_A/GET_B, which gives the clear-on-entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= 16'h0000;
        end else if (w_collecting && !w_in_fire && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + 16'h0001;
        end else begin
            r_idle_cnt <= 16'h0000;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    if (is_legal_op(in_data)) begin
                        w_state_next = GET_A;
                    end else if (!is_skip(in_data)) begin
                        w_state_next = RESP;
                    end
                end
            end
            GET_A: begin
                if (w_in_fire) begin
                    w_state_next = GET_B;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            GET_B: begin
                if (w_in_fire) begin
                    w_state_next = w_div0 ? RESP : WAIT;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (w_wait_done) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (w_out_fire) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
            end
            GET_A, GET_B: begin
                w_in_ready = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: ALU operands, response, latency counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alu_operation <= 8'h00;
            r_alu_data_a    <= 8'h00;
            r_alu_data_b    <= 8'h00;
            r_out_data      <= 8'h00;
            r_out_status    <= ST_OK;
            r_wait_cnt      <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        if (is_legal_op(in_data)) begin
                            r_alu_operation <= in_data;
                        end else if (!is_skip(in_data)) begin
                            // Echo the offending byte so the host can see
                            // what was rejected.
                            r_out_data   <= in_data;
                            r_out_status <= ST_BADOP;
                        end
                    end
                end
                GET_A: begin
                    if (w_in_fire) begin
                        r_alu_data_a <= in_data;
                    end
                end
                GET_B: begin
                    if (w_in_fire) begin
                        r_alu_data_b <= in_data;
                        if (w_div0) begin
                            r_out_data   <= DIV0_DATA;
                            r_out_status <= ST_DIV0;
                        end else begin
                            r_wait_cnt <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (w_wait_done) begin
                        r_out_data   <= alu_result;
                        r_out_status <= alu_overflow ? ST_OVF : ST_OK;
                    end
                end
                default: begin
                    // RESP: response held stable until it is taken.
                end
            endcase
        end
    end

    // Registered valid: rises on the edge that enters RESP and falls on the
    // transfer edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_next == RESP);
        end
    end

    // -----------------------------------------------------------------------
    // Output assignments
    // -----------------------------------------------------------------------
    assign in_ready      = w_in_ready;
    assign busy          = w_busy;
    assign alu_operation = r_alu_operation;
    assign alu_data_a    = r_alu_data_a;
    assign alu_data_b    = r_alu_data_b;
    assign out_data      = r_out_data;
    assign out_status    = r_out_status;
    assign out_valid     = r_out_valid;

endmodule : alu_command_sequencer
